dmem_responder: RTL and testbench

Memory-side responder for the pipelined RSA core's data port. It answers the core's MEM-stage load/store requests from a word-organised RAM. A byte-serial host port with its own handshake and state machine loads operands (keys, message blocks) and dumps results. While the host owns the memory, `cpu_hold` is asserted; the top level uses it to freeze the core.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the RSA core data-memory responder.
package dmem_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_READ  = 2'b01,
    CMD_NOP   = 2'b10
  } host_cmd_e;

  typedef enum logic [2:0] {
    HS_IDLE     = 3'd0,
    HS_WCOLLECT = 3'd1,
    HS_WCOMMIT  = 3'd2,
    HS_RFETCH   = 3'd3,
    HS_RSEND    = 3'd4
  } hstate_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Byte-serial host port: command/data handshake in, response handshake out.
interface dmem_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic              host_valid;
  logic              host_ready;
  logic [1:0]        host_cmd;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_byte;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_byte;

  modport slave (
    input  host_valid, host_cmd, host_addr, host_byte, rsp_ready,
    output host_ready, rsp_valid, rsp_byte
  );

  modport master (
    output host_valid, host_cmd, host_addr, host_byte, rsp_ready,
    input  host_ready, rsp_valid, rsp_byte
  );
endinterface

// File: rtl/dmem_ram.sv
// Word RAM: one synchronous write port, two combinational read ports.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [31:0]       rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [31:0]       rdata_b
);

  logic [31:0] mem [2**ADDR_W];

  // single write port, arbitration is done by the caller
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the RSA core data port plus a byte-serial
// host port that loads operands and dumps results while the core is held.
//
// state       | meaning
// ------------+------------------------------------------------------
// HS_IDLE     | core owns memory; host command accepted here
// HS_WCOLLECT | assembling a host write word, bytes 1..3 (LSB first)
// HS_WCOMMIT  | assembled word written to RAM at end of this cycle
// HS_RFETCH   | RAM word captured into the response register
// HS_RSEND    | response bytes offered LSB first, one per handshake
import dmem_pkg::*;

module dmem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadData,
  dmem_responder_if.slave   host,
  output logic              cpu_hold,
  output logic              addr_err
);

  hstate_e           state, state_nxt;
  logic [1:0]        count, count_nxt;
  logic [ADDR_W-1:0] haddr, haddr_nxt;
  logic [31:0]       word, word_nxt;
  logic              host_wr;

  logic [ADDR_W-1:0] core_idx;
  logic              in_range;
  logic [31:0]       core_rdata;
  logic [31:0]       host_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic [1:0]        unused_lsbs;

  // core addressing is word-based; the byte offset bits carry no meaning
  assign core_idx    = ALUOutM[ADDR_W+1:2];
  assign in_range    = ~|ALUOutM[31:ADDR_W+2];
  assign unused_lsbs = ALUOutM[1:0];

  assign cpu_hold        = (state != HS_IDLE);
  assign host.host_ready = (state == HS_IDLE) || (state == HS_WCOLLECT);

  assign ReadData = (MemtoRegM && in_range) ? core_rdata : 32'd0;

  // host commit wins the write port; core stores only while not held
  assign ram_we    = host_wr || (MemWriteM && !cpu_hold && in_range);
  assign ram_waddr = host_wr ? haddr : core_idx;
  assign ram_wdata = host_wr ? word  : WriteDataM;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (core_idx),
    .rdata_a (core_rdata),
    .raddr_b (haddr),
    .rdata_b (host_rdata)
  );

  // host FSM state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HS_IDLE;
      count <= 2'd0;
      haddr <= '0;
      word  <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      haddr <= haddr_nxt;
      word  <= word_nxt;
    end
  end

  // next-state, datapath updates and response outputs
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    haddr_nxt      = haddr;
    word_nxt       = word;
    host_wr        = 1'b0;
    host.rsp_valid = 1'b0;
    host.rsp_byte  = 8'd0;

    case (state)
      HS_IDLE: begin
        if (host.host_valid) begin
          if (host.host_cmd == CMD_WRITE) begin
            haddr_nxt     = host.host_addr;
            word_nxt[7:0] = host.host_byte;
            count_nxt     = 2'd1;
            state_nxt     = HS_WCOLLECT;
          end else if (host.host_cmd == CMD_READ) begin
            haddr_nxt = host.host_addr;
            state_nxt = HS_RFETCH;
          end
        end
      end
      HS_WCOLLECT: begin
        if (host.host_valid) begin
          word_nxt[{count, 3'b000} +: 8] = host.host_byte;
          count_nxt = count + 2'd1;
          if (count == 2'(BYTES_PER_WORD - 1)) state_nxt = HS_WCOMMIT;
        end
      end
      HS_WCOMMIT: begin
        host_wr   = 1'b1;
        state_nxt = HS_IDLE;
      end
      HS_RFETCH: begin
        word_nxt  = host_rdata;
        count_nxt = 2'd0;
        state_nxt = HS_RSEND;
      end
      HS_RSEND: begin
        host.rsp_valid = 1'b1;
        host.rsp_byte  = word[{count, 3'b000} +: 8];
        if (host.rsp_ready) begin
          count_nxt = count + 2'd1;
          if (count == 2'(BYTES_PER_WORD - 1)) state_nxt = HS_IDLE;
        end
      end
      default: state_nxt = HS_IDLE;
    endcase
  end

  // sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) addr_err <= 1'b0;
    else if ((MemWriteM || MemtoRegM) && !in_range) addr_err <= 1'b1;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Inputs change between falling and
// rising edge; outputs are sampled at or just after the falling edge.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int ADDR_W = 8;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadData;
  logic        cpu_hold;
  logic        addr_err;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder_if #(.ADDR_W(ADDR_W)) hif ();

  dmem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadData   (ReadData),
    .host       (hif.slave),
    .cpu_hold   (cpu_hold),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic core_store(input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = 1'b1;
    ALUOutM    = a;
    WriteDataM = d;
    @(negedge clk);
    MemWriteM  = 1'b0;
  endtask

  task automatic core_load(input logic [31:0] a, output logic [31:0] d);
    MemtoRegM = 1'b1;
    ALUOutM   = a;
    #1;
    d = ReadData;
    MemtoRegM = 1'b0;
  endtask

  // ph selects when a core store is issued alongside: 0..3 with that host
  // byte, 4 during the commit cycle, anything else for none
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [31:0] w,
                            input int ph, input logic [31:0] ca, input logic [31:0] cd,
                            output int hc);
    hc = 0;
    hif.host_valid = 1'b1;
    hif.host_cmd   = CMD_WRITE;
    hif.host_addr  = a;
    for (int i = 0; i < 4; i++) begin
      hif.host_byte = w[i*8 +: 8];
      MemWriteM  = (i == ph);
      ALUOutM    = ca;
      WriteDataM = cd;
      @(negedge clk);
      if (cpu_hold) hc++;
    end
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_NOP;
    MemWriteM  = (ph == 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      MemWriteM = 1'b0;
      if (cpu_hold) hc++;
      else break;
    end
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input bit toggle, output logic [31:0] w);
    int        got;
    bit        stalled;
    logic [7:0] held;
    got = 0;
    stalled = 1'b0;
    held = 8'd0;
    w = 32'd0;
    hif.host_valid = 1'b1;
    hif.host_cmd   = CMD_READ;
    hif.host_addr  = a;
    @(negedge clk);
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_NOP;
    for (int c = 0; c < 40 && got < 4; c++) begin
      hif.rsp_ready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (hif.rsp_valid) begin
        if (stalled) check("rsp_hold", {24'd0, hif.rsp_byte}, {24'd0, held});
        if (hif.rsp_ready) begin
          w[got*8 +: 8] = hif.rsp_byte;
          got++;
          stalled = 1'b0;
        end else begin
          held = hif.rsp_byte;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
    end
    hif.rsp_ready = 1'b0;
    check("rd_bytes_seen", got, 4);
  endtask

  logic [31:0] rd;
  int          hc;
  logic [31:0] w0, w1;
  bit          e_rdy, e_val;
  logic [7:0]  e_byte;

  initial begin
    reset          = 1'b0;
    MemWriteM      = 1'b0;
    MemtoRegM      = 1'b0;
    ALUOutM        = 32'd0;
    WriteDataM     = 32'd0;
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_NOP;
    hif.host_addr  = '0;
    hif.host_byte  = 8'd0;
    hif.rsp_ready  = 1'b0;

    // reset values during and right after reset
    repeat (2) @(negedge clk);
    check("rst_host_ready", hif.host_ready, 1);
    check("rst_rsp_valid", hif.rsp_valid, 0);
    check("rst_rsp_byte", hif.rsp_byte, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_addr_err", addr_err, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", hif.host_ready, 1);
    check("post_rst_hold", cpu_hold, 0);
    check("post_rst_valid", hif.rsp_valid, 0);

    // host write, then core load of the same word
    host_write(8'd5, 32'h12345678, -1, 32'd0, 32'd0, hc);
    check("wr_hold_cycles", hc, 4);
    core_load(32'h14, rd);
    check("ld_addr5", rd, 32'h12345678);
    core_load(32'h17, rd);
    check("ld_addr5_lsbs", rd, 32'h12345678);
    MemtoRegM = 1'b0;
    ALUOutM = 32'h14;
    #1;
    check("ld_no_strobe", ReadData, 0);

    // core store, host read with stalls
    @(negedge clk);
    core_store(32'h08, 32'hDEADBEEF);
    core_load(32'h08, rd);
    check("ld_addr2", rd, 32'hDEADBEEF);
    @(negedge clk);
    host_read(8'd2, 1'b1, rd);
    check("rd_b0", rd[7:0], 8'hEF);
    check("rd_b1", rd[15:8], 8'hBE);
    check("rd_b2", rd[23:16], 8'hAD);
    check("rd_b3", rd[31:24], 8'hDE);
    check("rd_after_idle", cpu_hold, 0);

    // out-of-range core accesses
    check("err_before", addr_err, 0);
    core_store(32'h0000_0408, 32'hCAFEF00D);
    check("err_after_st", addr_err, 1);
    core_load(32'h0000_0400, rd);
    check("ld_oor_zero", rd, 0);
    core_load(32'h08, rd);
    check("oor_st_dropped", rd, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("err_sticky", addr_err, 1);

    // core store during the commit of the same address: host wins
    host_write(8'd3, 32'h11223344, 4, 32'h0C, 32'h55667788, hc);
    core_load(32'h0C, rd);
    check("commit_collision", rd, 32'h11223344);

    // core store in the cycle the FSM leaves idle is performed
    @(negedge clk);
    host_write(8'd6, 32'h76543210, 0, 32'h1C, 32'h99AABBCC, hc);
    core_load(32'h1C, rd);
    check("leave_idle_store", rd, 32'h99AABBCC);
    core_load(32'h18, rd);
    check("leave_idle_host", rd, 32'h76543210);

    // reset while a response is pending
    @(negedge clk);
    hif.host_valid = 1'b1;
    hif.host_cmd   = CMD_READ;
    hif.host_addr  = 8'd5;
    @(negedge clk);
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_NOP;
    hif.rsp_ready  = 1'b0;
    for (int k = 0; k < 5 && !hif.rsp_valid; k++) @(negedge clk);
    check("abort_rsp_up", hif.rsp_valid, 1);
    reset = 1'b0;
    #1;
    check("abort_rsp_drop", hif.rsp_valid, 0);
    check("abort_hold", cpu_hold, 0);
    check("abort_err_clr", addr_err, 0);
    @(negedge clk);
    reset = 1'b1;

    // reset mid-write discards the partial word
    @(negedge clk);
    host_write(8'd9, 32'h01020304, -1, 32'd0, 32'd0, hc);
    hif.host_valid = 1'b1;
    hif.host_cmd   = CMD_WRITE;
    hif.host_addr  = 8'd9;
    hif.host_byte  = 8'hCC;
    @(negedge clk);
    hif.host_byte  = 8'hDD;
    @(negedge clk);
    hif.host_valid = 1'b0;
    hif.host_cmd   = CMD_NOP;
    check("partial_hold", cpu_hold, 1);
    reset = 1'b0;
    #1;
    check("partial_rst_hold", cpu_hold, 0);
    check("partial_rst_ready", hif.host_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    core_load(32'h24, rd);
    check("partial_no_write", rd, 32'h01020304);
    @(negedge clk);
    host_write(8'd9, 32'h0A0B0C0D, -1, 32'd0, 32'd0, hc);
    core_load(32'h24, rd);
    check("rewrite_after_rst", rd, 32'h0A0B0C0D);

    // back-to-back reads of addr 0 and the top address
    w0 = 32'hA1B2C3D4;
    w1 = 32'h0BADF00D;
    @(negedge clk);
    host_write(8'd0, w0, -1, 32'd0, 32'd0, hc);
    host_write(8'd255, w1, -1, 32'd0, 32'd0, hc);
    core_load(32'h3FC, rd);
    check("ld_top_addr", rd, w1);
    @(negedge clk);
    hif.host_valid = 1'b1;
    hif.host_cmd   = CMD_READ;
    hif.host_addr  = 8'd0;
    hif.rsp_ready  = 1'b1;
    for (int s = 0; s < 13; s++) begin
      if (s == 1) hif.host_addr = 8'd255;
      if (s == 7) begin
        hif.host_valid = 1'b0;
        hif.host_cmd   = CMD_NOP;
      end
      #1;
      e_rdy  = (s == 0) || (s == 6) || (s == 12);
      e_val  = (s >= 2 && s <= 5) || (s >= 8 && s <= 11);
      e_byte = 8'd0;
      if (s >= 2 && s <= 5)  e_byte = w0[(s-2)*8 +: 8];
      if (s >= 8 && s <= 11) e_byte = w1[(s-8)*8 +: 8];
      check($sformatf("b2b_ready_%0d", s), hif.host_ready, e_rdy);
      check($sformatf("b2b_valid_%0d", s), hif.rsp_valid, e_val);
      check($sformatf("b2b_byte_%0d", s), hif.rsp_byte, e_byte);
      @(negedge clk);
    end
    hif.rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
